subcounter_ctrl: RTL and testbench

SUBCOUNTER_CTRL -- requirements
Module: subcounter_ctrl

---
 rtl/subcounter_pkg.sv | 21 ++
 rtl/subcounter_carry_chain.sv | 27 ++
 rtl/subcounter_ctrl.sv | 110 +++++++++++
 tb/tb_subcounter_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/subcounter_pkg.sv
// Shared encodings for the chained sub-counter controller: segment commands,
// request opcodes and FSM states.
package subcounter_pkg;

    localparam logic [1:0] CMD_RESET = 2'b00;
    localparam logic [1:0] CMD_INC   = 2'b01;
    localparam logic [1:0] CMD_IDLE  = 2'b10;
    localparam logic [1:0] CMD_LOAD  = 2'b11;

    localparam logic [1:0] OP_CLEAR  = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b01;
    localparam logic [1:0] OP_NOP    = 2'b10;
    localparam logic [1:0] OP_LOAD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/subcounter_carry_chain.sv
// Ripple-carry command generator: a segment increments only when the increment
// request reaches it through lower segments that all read all-ones.
module subcounter_carry_chain
    import subcounter_pkg::*;
#(
    parameter int GRANULARITY = 4,
    parameter int NUM_SEG     = 4
) (
    input  logic                           inc_en,
    input  logic [NUM_SEG*GRANULARITY-1:0] seg_data,
    output logic [2*NUM_SEG-1:0]           cmd,
    output logic                           wrap
);

    logic carry;

    always_comb begin
        cmd   = '0;
        carry = inc_en;
        for (int i = 0; i < NUM_SEG; i++) begin
            cmd[2*i +: 2] = carry ? CMD_INC : CMD_IDLE;
            carry         = carry & (&seg_data[i*GRANULARITY +: GRANULARITY]);
        end
        wrap = carry;
    end

endmodule

// File: rtl/subcounter_ctrl.sv
// Sequencer for a chain of external counter segments: accepts CLEAR/ADD/NOP/LOAD
// requests and drives per-segment commands until the operation completes.
module subcounter_ctrl
    import subcounter_pkg::*;
#(
    parameter int GRANULARITY = 4,
    parameter int NUM_SEG     = 4,
    localparam int W          = NUM_SEG * GRANULARITY
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [W-1:0]         req_arg,
    input  logic [W-1:0]         seg_data_in,
    output logic [2*NUM_SEG-1:0] sub_command_out,
    output logic [W-1:0]         load_data_out,
    output logic                 done,
    output logic                 overflow
);

    state_t               state_q, state_d;
    logic [1:0]           op_q;
    logic [W-1:0]         rem_q;
    logic [W-1:0]         arg_q;
    logic                 accept;
    logic                 inc_en;
    logic                 ov_set;
    logic                 ov_clr;
    logic                 wrap;
    logic [2*NUM_SEG-1:0] chain_cmd;

    subcounter_carry_chain #(
        .GRANULARITY (GRANULARITY),
        .NUM_SEG     (NUM_SEG)
    ) u_carry_chain (
        .inc_en   (inc_en),
        .seg_data (seg_data_in),
        .cmd      (chain_cmd),
        .wrap     (wrap)
    );

    assign req_ready     = (state_q == ST_IDLE);
    assign done          = (state_q == ST_DONE);
    assign accept        = req_valid & req_ready;
    assign load_data_out = arg_q;

    always_comb begin
        state_d         = state_q;
        sub_command_out = {NUM_SEG{CMD_IDLE}};
        inc_en          = 1'b0;
        ov_set          = 1'b0;
        ov_clr          = 1'b0;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: begin
                case (op_q)
                    OP_CLEAR: begin
                        sub_command_out = {NUM_SEG{CMD_RESET}};
                        ov_clr          = 1'b1;
                        state_d         = ST_DONE;
                    end
                    OP_LOAD: begin
                        sub_command_out = {NUM_SEG{CMD_LOAD}};
                        ov_clr          = 1'b1;
                        state_d         = ST_DONE;
                    end
                    OP_ADD: begin
                        // The last increment (rem_q == 1) and a zero count both finish here.
                        if (rem_q != '0) begin
                            inc_en          = 1'b1;
                            sub_command_out = chain_cmd;
                            ov_set          = wrap;
                        end
                        if (rem_q <= W'(1)) state_d = ST_DONE;
                    end
                    default: state_d = ST_DONE;
                endcase
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            rem_q    <= '0;
            arg_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= req_op;
                rem_q <= req_arg;
                arg_q <= req_arg;
            end else if (inc_en) begin
                rem_q <= rem_q - W'(1);
            end
            if (ov_clr) begin
                overflow <= 1'b0;
            end else if (ov_set) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_subcounter_ctrl.sv
// Directed bench for subcounter_ctrl with two 4-bit behavioural segments.
module tb_subcounter_ctrl;

    localparam int G  = 4;
    localparam int NS = 2;
    localparam int W  = G * NS;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b10;
    logic [W-1:0]  req_arg = '0;
    logic [W-1:0]  seg_val = '0;
    logic [2*NS-1:0] sub_command_out;
    logic [W-1:0]  load_data_out;
    logic          done;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int seg1_inc_cnt = 0;
    int done_cnt = 0;

    subcounter_ctrl #(.GRANULARITY(G), .NUM_SEG(NS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_arg         (req_arg),
        .seg_data_in     (seg_val),
        .sub_command_out (sub_command_out),
        .load_data_out   (load_data_out),
        .done            (done),
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural segments (no reset, as in the real array).
    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            case (sub_command_out[2*i +: 2])
                2'b00:   seg_val[i*G +: G] <= '0;
                2'b01:   seg_val[i*G +: G] <= seg_val[i*G +: G] + 4'd1;
                2'b11:   seg_val[i*G +: G] <= load_data_out[i*G +: G];
                default: seg_val[i*G +: G] <= seg_val[i*G +: G];
            endcase
        end
    end

    always @(negedge clk) begin
        if (sub_command_out[3:2] == 2'b01) seg1_inc_cnt++;
        if (done) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request from IDLE; returns the number of EXEC cycles observed.
    task automatic run_req(input logic [1:0] op, input logic [W-1:0] arg, output int cyc);
        req_valid = 1'b1;
        req_op    = op;
        req_arg   = arg;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0;
        while (!done && cyc < 300) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        check_val("done_one_cycle", {31'd0, done}, 32'd0);
        check_val("ready_after_done", {31'd0, req_ready}, 32'd1);
    endtask

    int cyc;
    int s1, d0;
    int accepts;
    int acc_cyc[2];

    initial begin
        #12;
        check_val("rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("rst_done", {31'd0, done}, 32'd0);
        check_val("rst_overflow", {31'd0, overflow}, 32'd0);
        check_val("rst_cmd", {28'd0, sub_command_out}, 32'hA);
        check_val("rst_load_data", {24'd0, load_data_out}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // LOAD 0x0E then ADD 3
        run_req(2'b00, 8'h00, cyc);
        check_val("clear_cyc", cyc, 1);
        check_val("clear_val", {24'd0, seg_val}, 32'h00);
        run_req(2'b11, 8'h0E, cyc);
        check_val("load_cyc", cyc, 1);
        check_val("load_val", {24'd0, seg_val}, 32'h0E);
        check_val("load_data_out", {24'd0, load_data_out}, 32'h0E);
        s1 = seg1_inc_cnt;
        d0 = done_cnt;
        run_req(2'b01, 8'd3, cyc);
        check_val("add3_cyc", cyc, 3);
        check_val("add3_val", {24'd0, seg_val}, 32'h11);
        check_val("add3_seg1_incs", seg1_inc_cnt - s1, 1);
        check_val("add3_done_cnt", done_cnt - d0, 1);
        check_val("add3_ovf", {31'd0, overflow}, 32'd0);

        // wrap through all-ones, then CLEAR drops overflow
        run_req(2'b11, 8'hFE, cyc);
        run_req(2'b01, 8'd3, cyc);
        check_val("wrap_val", {24'd0, seg_val}, 32'h01);
        check_val("wrap_ovf", {31'd0, overflow}, 32'd1);
        run_req(2'b00, 8'h00, cyc);
        check_val("clr_after_wrap_val", {24'd0, seg_val}, 32'h00);
        check_val("clr_after_wrap_ovf", {31'd0, overflow}, 32'd0);

        // ADD 0
        run_req(2'b11, 8'h5A, cyc);
        run_req(2'b01, 8'd0, cyc);
        check_val("add0_cyc", cyc, 1);
        check_val("add0_val", {24'd0, seg_val}, 32'h5A);

        // held req_valid, ADD 2 twice from zero
        run_req(2'b00, 8'h00, cyc);
        d0 = done_cnt;
        accepts = 0;
        acc_cyc[0] = 0;
        acc_cyc[1] = 0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_arg   = 8'd2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req_ready && req_valid) begin
                acc_cyc[accepts] = c;
                accepts++;
                if (accepts == 2) begin
                    @(posedge clk); #1;
                    req_valid = 1'b0;
                end
            end
        end
        check_val("held_accepts", accepts, 2);
        check_val("held_gap", acc_cyc[1] - acc_cyc[0], 4);
        check_val("held_val", {24'd0, seg_val}, 32'h04);
        check_val("held_done_cnt", done_cnt - d0, 2);
        @(posedge clk); #1;

        // reset in the 2nd EXEC cycle of ADD 5
        run_req(2'b00, 8'h00, cyc);
        d0 = done_cnt;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_arg   = 8'd5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_cmd", {28'd0, sub_command_out}, 32'hA);
        check_val("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        check_val("mid_rst_done", {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("mid_rst_val", {24'd0, seg_val}, 32'h01);
        rst_n = 1'b1;
        check_val("mid_rst_no_done", done_cnt - d0, 0);

        // NOP straight after reset release
        run_req(2'b10, 8'h77, cyc);
        check_val("nop_cyc", cyc, 1);
        check_val("nop_val", {24'd0, seg_val}, 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
